// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, bus layouts and FSM encoding for the MIPS main control
package mips_ctrl_pkg;

  localparam int NB_OPCODE  = 6;
  localparam int NB_REG     = 5;
  localparam int NB_CTRL_EX = 6;
  localparam int NB_CTRL_M  = 9;
  localparam int NB_CTRL_WB = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  // Bit positions inside the MEM bus [SB,SH,LB,LH,Unsigned,BNEQ,Branch,MemRead,MemWrite]
  localparam int M_MEMWRITE = 0;
  localparam int M_MEMREAD  = 1;
  localparam int M_BRANCH   = 2;
  localparam int M_BNEQ     = 3;
  localparam int M_UNSIGNED = 4;
  localparam int EX_REGDST  = 0;
  localparam int EX_ALUSRC  = 5;
  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [NB_CTRL_WB-1:0] wb;
    logic [NB_CTRL_M-1:0]  mem;
    logic [NB_CTRL_EX-1:0] exc;
    logic jump;
    logic jal;
    logic jr;
    logic jalr;
    logic shift;
    logic shamt;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct to control-bus map
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_OPCODE-1:0] i_funct,
  output ctrl_t                o_ctrl,
  output logic                 o_halt,
  output logic                 o_illegal,
  output logic                 o_uses_rt
);

  always_comb begin
    o_ctrl    = '0;
    o_halt    = 1'b0;
    o_illegal = 1'b0;
    o_uses_rt = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_uses_rt  = 1'b1;
        o_ctrl.wb  = 2'b10;
        o_ctrl.exc = 6'b000101;
        case (i_funct)
          FN_SLL, FN_SRL, FN_SRA: begin
            o_ctrl.shift = 1'b1;
            o_ctrl.shamt = 1'b1;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: o_ctrl.shift = 1'b1;
          FN_JR: begin
            o_ctrl.exc = 6'b000000;
            o_ctrl.jr  = 1'b1;
          end
          FN_JALR: begin
            o_ctrl.exc  = 6'b000001;
            o_ctrl.jalr = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LB:  begin o_ctrl.wb = 2'b11; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b001000010; end
      OP_LH:  begin o_ctrl.wb = 2'b11; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b000100010; end
      OP_LW, OP_LWU: begin o_ctrl.wb = 2'b11; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b000000010; end
      OP_LBU: begin o_ctrl.wb = 2'b11; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b001010010; end
      OP_LHU: begin o_ctrl.wb = 2'b11; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b000110010; end
      OP_SB:  begin o_uses_rt = 1'b1; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b100000001; end
      OP_SH:  begin o_uses_rt = 1'b1; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b010000001; end
      OP_SW:  begin o_uses_rt = 1'b1; o_ctrl.exc = 6'b100000; o_ctrl.mem = 9'b000000001; end
      OP_ADDI: begin o_ctrl.wb = 2'b10; o_ctrl.exc = 6'b100110; end
      OP_ANDI: begin o_ctrl.wb = 2'b10; o_ctrl.exc = 6'b101000; end
      OP_ORI:  begin o_ctrl.wb = 2'b10; o_ctrl.exc = 6'b101010; end
      OP_XORI: begin o_ctrl.wb = 2'b10; o_ctrl.exc = 6'b101100; end
      OP_LUI:  begin o_ctrl.wb = 2'b10; o_ctrl.exc = 6'b101110; end
      OP_SLTI: begin o_ctrl.wb = 2'b10; o_ctrl.exc = 6'b110000; end
      OP_BEQ: begin o_uses_rt = 1'b1; o_ctrl.mem = 9'b000000100; o_ctrl.exc = 6'b000010; end
      OP_BNE: begin o_uses_rt = 1'b1; o_ctrl.mem = 9'b000001000; o_ctrl.exc = 6'b000010; end
      OP_J:   o_ctrl.jump = 1'b1;
      OP_JAL: begin o_ctrl.wb = 2'b10; o_ctrl.jal = 1'b1; end
      OP_HALT: o_halt = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe_hazard.sv
// rtl/control_pipe_hazard.sv - ID-stage main control with load-use stall, flush, HALT and error count
module control_pipe_hazard
  import mips_ctrl_pkg::*;
#(
  parameter int NB_ERRCNT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [NB_OPCODE-1:0]  i_opcode,
  input  logic [NB_OPCODE-1:0]  i_funct,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic                  i_flush,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic                  o_jump,
  output logic                  o_jal,
  output logic                  o_jr,
  output logic                  o_jalr,
  output logic                  o_shift,
  output logic                  o_shamt,
  output logic                  o_valid,
  output logic                  o_stall,
  output logic                  o_halted,
  output logic                  o_illegal,
  output logic [NB_ERRCNT-1:0]  o_illegal_cnt
);

  ctrl_t             dec;
  logic              dec_halt;
  logic              dec_illegal;
  logic              dec_uses_rt;
  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [NB_REG-1:0] ex_rt_q;
  logic              illegal_q;
  logic [NB_ERRCNT-1:0] cnt_q;
  state_e            state_q;
  logic              hazard;
  logic              issue;

  ctrl_decode u_decode (
    .i_opcode  (i_opcode),
    .i_funct   (i_funct),
    .o_ctrl    (dec),
    .o_halt    (dec_halt),
    .o_illegal (dec_illegal),
    .o_uses_rt (dec_uses_rt)
  );

  assign hazard = i_valid & valid_q & ctrl_q.mem[M_MEMREAD] & (ex_rt_q != '0) &
                  ((ex_rt_q == i_rs) | (dec_uses_rt & (ex_rt_q == i_rt)));

  // HALT state pins the front end; otherwise a flush cancels any pending hazard
  assign o_stall = (state_q == ST_HALT) | (hazard & ~i_flush);
  assign issue   = i_valid & ~i_flush & ~o_stall;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      ex_rt_q   <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_RUN;
    end else begin
      ctrl_q    <= issue ? dec : '0;
      valid_q   <= issue;
      ex_rt_q   <= issue ? i_rt : '0;
      illegal_q <= issue & dec_illegal;
      if (issue & dec_illegal & (cnt_q != '1))
        cnt_q <= cnt_q + NB_ERRCNT'(1);
      case (state_q)
        ST_RUN: begin
          if (issue & dec_halt)      state_q <= ST_HALT;
          else if (hazard & ~i_flush) state_q <= ST_STALL;
        end
        ST_STALL: state_q <= (issue & dec_halt) ? ST_HALT : ST_RUN;
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign o_ctrl_wb_bus  = ctrl_q.wb;
  assign o_ctrl_mem_bus = ctrl_q.mem;
  assign o_ctrl_exc_bus = ctrl_q.exc;
  assign o_jump         = ctrl_q.jump;
  assign o_jal          = ctrl_q.jal;
  assign o_jr           = ctrl_q.jr;
  assign o_jalr         = ctrl_q.jalr;
  assign o_shift        = ctrl_q.shift;
  assign o_shamt        = ctrl_q.shamt;
  assign o_valid        = valid_q;
  assign o_halted       = (state_q == ST_HALT);
  assign o_illegal      = illegal_q;
  assign o_illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_control_pipe_hazard.sv
// tb/tb_control_pipe_hazard.sv - directed self-checking bench for control_pipe_hazard
module tb_control_pipe_hazard;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000011;
  localparam logic [5:0] HALT = 6'b111111;
  localparam logic [5:0] ILL  = 6'b010011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SLL = 6'b000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid, flush;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic [1:0] wb_bus;
  logic [8:0] mem_bus;
  logic [5:0] exc_bus;
  logic       jump, jal, jr, jalr, shift, shamt;
  logic       o_valid, o_stall, o_halted, o_illegal;
  logic [7:0] o_illegal_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_pipe_hazard dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_valid        (valid),
    .i_opcode       (opcode),
    .i_funct        (funct),
    .i_rs           (rs),
    .i_rt           (rt),
    .i_flush        (flush),
    .o_ctrl_wb_bus  (wb_bus),
    .o_ctrl_mem_bus (mem_bus),
    .o_ctrl_exc_bus (exc_bus),
    .o_jump         (jump),
    .o_jal          (jal),
    .o_jr           (jr),
    .o_jalr         (jalr),
    .o_shift        (shift),
    .o_shamt        (shamt),
    .o_valid        (o_valid),
    .o_stall        (o_stall),
    .o_halted       (o_halted),
    .o_illegal      (o_illegal),
    .o_illegal_cnt  (o_illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] s, input logic [4:0] t, input logic fl);
    valid = v; opcode = op; funct = fn; rs = s; rt = t; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bus(input logic [1:0] w, input logic [8:0] m, input logic [5:0] e);
    return {15'd0, w, m, e};
  endfunction

  function automatic logic [31:0] obs_bus();
    return {15'd0, wb_bus, mem_bus, exc_bus};
  endfunction

  function automatic logic [31:0] obs_flags();
    return {26'd0, jump, jal, jr, jalr, shift, shamt};
  endfunction

  initial begin
    drv(1'b0, RT, F_ADD, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   32'(o_valid), 0);
    chk("rst_bus",     obs_bus(), 0);
    chk("rst_flags",   obs_flags(), 0);
    chk("rst_halted",  32'(o_halted), 0);
    chk("rst_illegal", 32'(o_illegal), 0);
    chk("rst_cnt",     32'(o_illegal_cnt), 0);
    chk("rst_stall",   32'(o_stall), 0);
    rst_n = 1'b1;

    // LW $9 then ADD using $9 as rs: one stall, one bubble, then ADD issues
    drv(1'b1, LW, 6'd0, 5'd2, 5'd9, 1'b0);
    #1 chk("lw_stall", 32'(o_stall), 0);
    tick();
    chk("lw_valid", 32'(o_valid), 1);
    chk("lw_bus", obs_bus(), bus(2'b11, 9'b000000010, 6'b100000));
    drv(1'b1, RT, F_ADD, 5'd9, 5'd3, 1'b0);
    #1 chk("add_stall", 32'(o_stall), 1);
    tick();
    chk("bubble_valid", 32'(o_valid), 0);
    chk("bubble_bus", obs_bus(), 0);
    chk("add_stall_gone", 32'(o_stall), 0);
    tick();
    chk("add_valid", 32'(o_valid), 1);
    chk("add_bus", obs_bus(), bus(2'b10, 9'b0, 6'b000101));
    chk("add_next_stall", 32'(o_stall), 0);

    // rt = 0 never hazards
    drv(1'b1, LW, 6'd0, 5'd2, 5'd0, 1'b0);
    tick();
    drv(1'b1, RT, F_ADD, 5'd0, 5'd0, 1'b0);
    #1 chk("rt0_stall", 32'(o_stall), 0);
    tick();
    chk("rt0_valid", 32'(o_valid), 1);

    // store reads rt: stalls
    drv(1'b1, LW, 6'd0, 5'd2, 5'd9, 1'b0);
    tick();
    drv(1'b1, SW, 6'd0, 5'd4, 5'd9, 1'b0);
    #1 chk("sw_stall", 32'(o_stall), 1);
    tick();
    chk("sw_bubble", 32'(o_valid), 0);
    tick();
    chk("sw_valid", 32'(o_valid), 1);
    chk("sw_bus", obs_bus(), bus(2'b00, 9'b000000001, 6'b100000));

    // ADDI only writes rt: no stall
    drv(1'b1, LW, 6'd0, 5'd2, 5'd9, 1'b0);
    tick();
    drv(1'b1, ADDI, 6'd0, 5'd4, 5'd9, 1'b0);
    #1 chk("addi_stall", 32'(o_stall), 0);
    tick();
    chk("addi_valid", 32'(o_valid), 1);
    chk("addi_bus", obs_bus(), bus(2'b10, 9'b0, 6'b100110));

    // flush overrides a pending load-use hazard
    drv(1'b1, LW, 6'd0, 5'd2, 5'd9, 1'b0);
    tick();
    drv(1'b1, BEQ, 6'd0, 5'd9, 5'd5, 1'b1);
    #1 chk("flush_stall", 32'(o_stall), 0);
    tick();
    chk("flush_valid", 32'(o_valid), 0);
    chk("flush_bus", obs_bus(), 0);
    drv(1'b1, RT, F_ADD, 5'd9, 5'd3, 1'b0);
    #1 chk("postflush_stall", 32'(o_stall), 0);
    tick();
    chk("postflush_valid", 32'(o_valid), 1);

    // illegal opcode under flush is ignored
    drv(1'b1, ILL, 6'd0, 5'd0, 5'd0, 1'b1);
    tick();
    chk("ill_flush_pulse", 32'(o_illegal), 0);
    chk("ill_flush_cnt", 32'(o_illegal_cnt), 0);

    // jump/shift flags
    drv(1'b1, RT, F_SLL, 5'd0, 5'd3, 1'b0);
    tick();
    chk("sll_flags", obs_flags(), 32'b000011);
    chk("sll_bus", obs_bus(), bus(2'b10, 9'b0, 6'b000101));
    drv(1'b1, J, 6'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("j_flags", obs_flags(), 32'b100000);
    chk("j_bus", obs_bus(), 0);
    drv(1'b1, JAL, 6'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("jal_flags", obs_flags(), 32'b010000);
    chk("jal_bus", obs_bus(), bus(2'b10, 9'b0, 6'b0));

    // 300 illegal opcodes: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      drv(1'b1, ILL, 6'd0, 5'd0, 5'd0, 1'b0);
      tick();
      chk("ill_pulse", 32'(o_illegal), 1);
      chk("ill_nop", obs_bus(), 0);
      chk("ill_cnt", 32'(o_illegal_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    drv(1'b0, RT, F_ADD, 5'd0, 5'd0, 1'b0);
    tick();
    chk("ill_pulse_end", 32'(o_illegal), 0);
    chk("ill_cnt_hold", 32'(o_illegal_cnt), 255);

    // asynchronous reset mid-stream
    drv(1'b1, LW, 6'd0, 5'd2, 5'd9, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(o_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(o_valid), 0);
    chk("arst_bus",    obs_bus(), 0);
    chk("arst_cnt",    32'(o_illegal_cnt), 0);
    chk("arst_halted", 32'(o_halted), 0);
    chk("arst_stall",  32'(o_stall), 0);
    drv(1'b0, RT, F_ADD, 5'd0, 5'd0, 1'b0);
    #2 rst_n = 1'b1;

    // HALT together with flush is ignored
    drv(1'b1, HALT, 6'd0, 5'd0, 5'd0, 1'b1);
    tick();
    chk("halt_flush_halted", 32'(o_halted), 0);
    chk("halt_flush_valid", 32'(o_valid), 0);
    drv(1'b1, RT, F_ADD, 5'd1, 5'd2, 1'b0);
    tick();
    chk("halt_flush_run", 32'(o_halted), 0);
    chk("halt_flush_add", 32'(o_valid), 1);

    // HALT latches and bubbles every following cycle
    drv(1'b1, HALT, 6'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("halt_halted", 32'(o_halted), 1);
    chk("halt_bus", obs_bus(), 0);
    drv(1'b1, RT, F_ADD, 5'd1, 5'd2, 1'b0);
    #1 chk("halt_stall", 32'(o_stall), 1);
    tick();
    chk("halt_bubble", 32'(o_valid), 0);
    chk("halt_bubble_bus", obs_bus(), 0);
    drv(1'b1, RT, F_ADD, 5'd1, 5'd2, 1'b1);
    #1 chk("halt_flush_stall", 32'(o_stall), 1);
    tick();
    chk("halt_stays", 32'(o_halted), 1);
    chk("halt_bubble2", 32'(o_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_pipe_hazard.md
Name: control_pipe_hazard

Overview:
Pipelined main-control unit for the 5-stage MIPS core. It decodes opcode/funct in ID and drives registered control buses into the ID/EX boundary. It also detects load-use hazards, inserts bubbles, squashes wrong-path instructions on flush, latches a HALT instruction, and counts illegal opcodes.

Parameters:
NB_OPCODE, 6, opcode and funct width
NB_REG, 5, register-specifier width
NB_CTRL_EX, 6, EX bus width: [ALUSrc, AluOp[3:0], RegDst]
NB_CTRL_M, 9, MEM bus width: [SB, SH, LB, LH, Unsigned, BNEQ, Branch, MemRead, MemWrite]
NB_CTRL_WB, 2, WB bus width: [RegWrite, MemtoReg]
NB_ERRCNT, 8, illegal-opcode counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-low reset
i_valid  in  1  ID holds a valid instruction
i_opcode  in  NB_OPCODE  instr[31:26]
i_funct  in  NB_OPCODE  instr[5:0]
i_rs  in  NB_REG  instr[25:21]
i_rt  in  NB_REG  instr[20:16]
i_flush  in  1  branch/jump resolved taken; squash ID
o_ctrl_wb_bus  out  NB_CTRL_WB  registered
o_ctrl_mem_bus  out  NB_CTRL_M  registered
o_ctrl_exc_bus  out  NB_CTRL_EX  registered
o_jump, o_jal, o_jr, o_jalr, o_shift, o_shamt  out  1 each  registered
o_valid  out  1  ID/EX slot holds a real instruction
o_stall  out  1  combinational; hold PC and IF/ID this cycle
o_halted  out  1  HALT latched
o_illegal  out  1  one-cycle pulse, registered
o_illegal_cnt  out  NB_ERRCNT  saturating count

Behaviour:
- Reset (i_rst=0, async): all registered outputs 0, state RUN, counter 0. Flops only; no combinational self-loops.
- Decode is combinational and feeds the ID/EX flops. Latency is 1 cycle from ID inputs to outputs.
- Decode table:
  - R-type: wb 10, mem 0, exc 000101. SLL/SRL/SRA set shift and shamt. SLLV/SRLV/SRAV set shift. JR: exc 0, jr=1. JALR: exc 000001, jalr=1.
  - Loads: wb 11, exc 100000, mem as follows: LB 001000010, LH 000100010, LW/LWU 000000010, LBU 001010010, LHU 000110010.
  - Stores: wb 00, exc 100000, mem as follows: SB 100000001, SH 010000001, SW 000000001.
  - Immediates: wb 10, mem 0, exc as follows: ADDI 100110, ANDI 101000, ORI 101010, XORI 101100, LUI 101110, SLTI 110000.
  - BEQ: mem 000000100, exc 000010. BNE: mem 000001000, exc 000010.
  - J: jump=1. JAL: wb 10, jal=1.
  - HALT: opcode 111111.
  - Any other opcode is illegal: decodes as a NOP and raises o_illegal.
- Load-use hazard:
  - Internal EX-stage tracking: ex_memread (MemRead of the ID/EX slot) and ex_rt.
  - o_stall = i_valid & o_valid & ex_memread & ex_rt!=0 & (ex_rt==i_rs | (uses_rt & ex_rt==i_rt)).
  - uses_rt covers R-type, stores, BEQ and BNE.
  - While stalled, the ID/EX slot loads a bubble (all buses 0, o_valid=0).
- FSM:
  - RUN: normal. A stall moves to STALL; a valid unflushed HALT moves to HALT.
  - STALL: lasts exactly 1 cycle, then returns to RUN. The held instruction re-decodes and o_stall is 0, because the load has moved to MEM.
  - HALT: o_halted=1; ID/EX forced to bubble every cycle; o_stall=1. Exit only by reset.
- Flush: i_flush=1 loads a bubble and overrides stall (o_stall=0). A HALT or illegal opcode in ID that same cycle is ignored: no state change, no count.
- Invalid ID (i_valid=0): bubble, no hazard, no count.
- Illegal opcode: o_illegal pulses for one cycle. o_illegal_cnt increments and saturates at 2^NB_ERRCNT-1 with no wrap.
- Bubble-insertion priority: reset > HALT state > flush > stall > decode.

Decomposition:
- Package mips_ctrl_pkg: opcode and funct localparams, bus-position localparams, FSM state encoding (RUN=0, STALL=1, HALT=2), and the HALT opcode.
- Sub-module ctrl_decode: pure combinational opcode/funct to bus/flag map, plus illegal and uses_rt outputs.
- Top level holds hazard logic, FSM, ID/EX flops and counter.

Test Plan:
- Reset mid-stream: drive LW then pull i_rst low asynchronously -> all outputs 0 immediately, state RUN, o_illegal_cnt=0.
- LW $t1 (rt=9) then ADD with rs=9 -> o_stall=1 for exactly one cycle with a bubble (o_valid=0), then ADD issues with wb=10, exc=000101. Repeat with rt=0 -> no stall.
- SW with rt equal to the prior LW rt -> stall. ADDI with rt equal to the prior LW rt -> no stall, since uses_rt=0.
- BEQ followed by i_flush=1 while a load-use hazard is pending -> o_stall=0, bubble issued, no STALL state.
- HALT (opcode 111111) valid -> o_halted=1 the next cycle and bubbles thereafter. HALT arriving together with i_flush=1 -> ignored.
- 300 illegal opcodes (e.g. 010011) -> o_illegal pulses for each, o_illegal_cnt saturates at 255, every slot is a NOP.
